// File: rtl/mirfak_muldiv_pkg.sv
// Shared encodings for the M-extension sequencer: FSM states, funct3 names
// and the RISC-V divide special-case constants.
package mirfak_muldiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_DIV_WAIT = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN  = 32'h8000_0000;

endpackage

// File: rtl/mirfak_muldiv_fastpath.sv
// Combinational resolver for divide-by-zero and signed-overflow divides,
// which have architecturally fixed results and never need the divider.
module mirfak_muldiv_fastpath
  import mirfak_muldiv_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        hit_o,
  output logic [31:0] result_o
);

  always_comb begin
    hit_o    = 1'b0;
    result_o = '0;
    if (b_i == '0) begin
      case (funct3_i)
        F3_DIV, F3_DIVU: begin
          hit_o    = 1'b1;
          result_o = ALL_ONES;
        end
        F3_REM, F3_REMU: begin
          hit_o    = 1'b1;
          result_o = a_i;
        end
        default: ;
      endcase
    end else if (a_i == INT_MIN && b_i == ALL_ONES) begin
      case (funct3_i)
        F3_DIV: begin
          hit_o    = 1'b1;
          result_o = INT_MIN;
        end
        F3_REM: begin
          hit_o    = 1'b1;
          result_o = '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mirfak_muldiv_ctrl.sv
// EX-stage sequencer for MUL/DIV: resolves cached and trivial ops locally,
// otherwise dispatches to the multiplier or divider and holds the result for EX/WB.
module mirfak_muldiv_ctrl
  import mirfak_muldiv_pkg::*;
#(
  parameter bit ENABLE_CACHE    = 1'b1,
  parameter bit ENABLE_FASTPATH = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        op_valid_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic        advance_i,
  input  logic        abort_i,
  output logic        mult_enable_o,
  output logic [1:0]  mult_cmd_o,
  input  logic        mult_ack_i,
  input  logic [31:0] mult_result_i,
  output logic        div_enable_o,
  output logic [1:0]  div_cmd_o,
  input  logic        div_ack_i,
  input  logic [31:0] div_result_i,
  output logic        unit_abort_o,
  output logic        busy_o,
  output logic [31:0] result_o
);

  state_e      state_q;
  logic [31:0] result_q;

  // Operands of the op currently in a unit; they become the cache entry on ack.
  logic [2:0]  pendF3_q;
  logic [31:0] pendA_q;
  logic [31:0] pendB_q;

  logic        cacheValid_q;
  logic [2:0]  cacheF3_q;
  logic [31:0] cacheA_q;
  logic [31:0] cacheB_q;
  logic [31:0] cacheResult_q;

  logic        fastHitRaw;
  logic [31:0] fastResult;
  logic        fastHit;
  logic        cacheHit;
  logic        inWait;
  logic        waitKill;

  mirfak_muldiv_fastpath u_fastpath (
    .funct3_i (funct3_i),
    .a_i      (op_a_i),
    .b_i      (op_b_i),
    .hit_o    (fastHitRaw),
    .result_o (fastResult)
  );

  assign fastHit  = ENABLE_FASTPATH && fastHitRaw;
  assign cacheHit = ENABLE_CACHE && cacheValid_q && (funct3_i == cacheF3_q) &&
                    (op_a_i == cacheA_q) && (op_b_i == cacheB_q);

  assign inWait   = (state_q == ST_MUL_WAIT) || (state_q == ST_DIV_WAIT);
  // A pipeline clear that drops op_valid mid-operation kills the unit like an abort.
  assign waitKill = inWait && (abort_i || !op_valid_i);

  assign busy_o        = op_valid_i && (state_q != ST_DONE) && !rst_i;
  assign unit_abort_o  = waitKill;
  assign mult_enable_o = (state_q == ST_MUL_WAIT);
  assign div_enable_o  = (state_q == ST_DIV_WAIT);
  assign mult_cmd_o    = mult_enable_o ? pendF3_q[1:0] : 2'b00;
  assign div_cmd_o     = div_enable_o ? pendF3_q[1:0] : 2'b00;
  assign result_o      = result_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      result_q      <= '0;
      pendF3_q      <= '0;
      pendA_q       <= '0;
      pendB_q       <= '0;
      cacheValid_q  <= 1'b0;
      cacheF3_q     <= '0;
      cacheA_q      <= '0;
      cacheB_q      <= '0;
      cacheResult_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (op_valid_i && !abort_i) begin
            if (cacheHit) begin
              result_q <= cacheResult_q;
              state_q  <= ST_DONE;
            end else if (fastHit) begin
              result_q <= fastResult;
              state_q  <= ST_DONE;
            end else begin
              pendF3_q <= funct3_i;
              pendA_q  <= op_a_i;
              pendB_q  <= op_b_i;
              state_q  <= funct3_i[2] ? ST_DIV_WAIT : ST_MUL_WAIT;
            end
          end
        end
        ST_MUL_WAIT, ST_DIV_WAIT: begin
          if (waitKill) begin
            state_q <= ST_IDLE;
          end else if ((state_q == ST_MUL_WAIT && mult_ack_i) ||
                       (state_q == ST_DIV_WAIT && div_ack_i)) begin
            result_q      <= (state_q == ST_MUL_WAIT) ? mult_result_i : div_result_i;
            cacheResult_q <= (state_q == ST_MUL_WAIT) ? mult_result_i : div_result_i;
            cacheValid_q  <= 1'b1;
            cacheF3_q     <= pendF3_q;
            cacheA_q      <= pendA_q;
            cacheB_q      <= pendB_q;
            state_q       <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (abort_i || advance_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mirfak_muldiv_ctrl.sv
// Self-checking bench: the bench plays both units and predicts results,
// latency and cache behaviour from RISC-V M-extension arithmetic.
module tb_mirfak_muldiv_ctrl;
  import mirfak_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        opValid = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] opA = '0;
  logic [31:0] opB = '0;
  logic        advance = 1'b0;
  logic        abort = 1'b0;
  logic        multEn;
  logic [1:0]  multCmd;
  logic        multAck = 1'b0;
  logic [31:0] multResult = '0;
  logic        divEn;
  logic [1:0]  divCmd;
  logic        divAck = 1'b0;
  logic [31:0] divResult = '0;
  logic        unitAbort;
  logic        busy;
  logic [31:0] result;

  int checkCount = 0;
  int failCount  = 0;

  // Reference cache: last op that completed through a unit without being killed.
  bit          mValid = 1'b0;
  logic [2:0]  mF3 = '0;
  logic [31:0] mA = '0;
  logic [31:0] mB = '0;

  mirfak_muldiv_ctrl dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .op_valid_i    (opValid),
    .funct3_i      (funct3),
    .op_a_i        (opA),
    .op_b_i        (opB),
    .advance_i     (advance),
    .abort_i       (abort),
    .mult_enable_o (multEn),
    .mult_cmd_o    (multCmd),
    .mult_ack_i    (multAck),
    .mult_result_i (multResult),
    .div_enable_o  (divEn),
    .div_cmd_o     (divCmd),
    .div_ack_i     (divAck),
    .div_result_i  (divResult),
    .unit_abort_o  (unitAbort),
    .busy_o        (busy),
    .result_o      (result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] refCalc(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    logic [31:0] r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = '0;
    r  = '0;
    case (f3)
      F3_MUL:    r = a * b;
      F3_MULH:   begin p = sa * sb; r = p[63:32]; end
      F3_MULHSU: begin p = sa * ub; r = p[63:32]; end
      F3_MULHU:  begin p = ua * ub; r = p[63:32]; end
      F3_DIV: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else r = $signed(a) / $signed(b);
      end
      F3_DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      F3_REM: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
        else r = $signed(a) % $signed(b);
      end
      default:   r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One complete op: issue, unit wait (lat cycles, optional kill at cycle abortAt),
  // then DONE held for stall cycles before advance.
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                               input int lat, input int stall, input int abortAt,
                               input bit dropValid);
    logic [31:0] exp;
    bit isDiv, fast, hit, useUnit, aborted;
    exp     = refCalc(f3, a, b);
    isDiv   = f3[2];
    fast    = isDiv && (b == 0 || ((f3 == F3_DIV || f3 == F3_REM) &&
                                   a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    hit     = mValid && mF3 == f3 && mA == a && mB == b;
    useUnit = !hit && !fast;
    aborted = 1'b0;

    @(negedge clk);
    opValid = 1'b1; funct3 = f3; opA = a; opB = b;
    advance = 1'b0; abort = 1'b0; multAck = 1'b0; divAck = 1'b0;
    #1;
    checkOutput("issue_busy", busy, 1);
    checkOutput("issue_mult_en", multEn, 0);
    checkOutput("issue_div_en", divEn, 0);

    if (useUnit) begin
      for (int k = 1; k <= lat && !aborted; k++) begin
        @(negedge clk);
        if (isDiv) begin
          divAck     = (k == lat);
          divResult  = exp;
          multAck    = ($urandom_range(0, 3) == 0);
          multResult = ~exp;
        end else begin
          multAck    = (k == lat);
          multResult = exp;
          divAck     = ($urandom_range(0, 3) == 0);
          divResult  = ~exp;
        end
        if (k == abortAt) begin
          if (dropValid) opValid = 1'b0;
          else abort = 1'b1;
        end
        #1;
        checkOutput("wait_mult_en", multEn, !isDiv);
        checkOutput("wait_div_en", divEn, isDiv);
        if (isDiv) checkOutput("wait_div_cmd", divCmd, f3[1:0]);
        else checkOutput("wait_mult_cmd", multCmd, f3[1:0]);
        checkOutput("wait_unit_abort", unitAbort, k == abortAt);
        checkOutput("wait_busy", busy, !(k == abortAt && dropValid));
        if (k == abortAt) aborted = 1'b1;
      end
    end

    if (aborted) begin
      @(negedge clk);
      opValid = 1'b0; abort = 1'b0; multAck = 1'b0; divAck = 1'b0;
      #1;
      checkOutput("kill_mult_en", multEn, 0);
      checkOutput("kill_div_en", divEn, 0);
      checkOutput("kill_unit_abort", unitAbort, 0);
      return;
    end

    if (useUnit) begin
      mValid = 1'b1; mF3 = f3; mA = a; mB = b;
    end

    for (int s = 0; s <= stall; s++) begin
      @(negedge clk);
      multAck = 1'b0; divAck = 1'b0;
      multResult = $urandom; divResult = $urandom;
      advance = (s == stall);
      #1;
      checkOutput("done_busy", busy, 0);
      checkOutput("done_result", result, exp);
      checkOutput("done_mult_en", multEn, 0);
      checkOutput("done_div_en", divEn, 0);
    end

    @(negedge clk);
    opValid = 1'b0; advance = 1'b0;
    #1;
    checkOutput("idle_mult_en", multEn, 0);
    checkOutput("idle_div_en", divEn, 0);
    checkOutput("idle_unit_abort", unitAbort, 0);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0]  rf3;
    logic [31:0] ra, rb;
    int          rAbort;

    $display("[TB] reset checks");
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_result", result, 0);
    checkOutput("rst_mult_en", multEn, 0);
    checkOutput("rst_div_en", divEn, 0);
    checkOutput("rst_unit_abort", unitAbort, 0);
    checkOutput("rst_cmds", {multCmd, divCmd}, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] directed ops");
    applyStimulus(F3_MUL, 32'd7, 32'd6, 2, 0, 0, 0);
    applyStimulus(F3_DIVU, 32'd100, 32'd7, 3, 0, 0, 0);
    applyStimulus(F3_REMU, 32'd100, 32'd7, 3, 0, 0, 0);
    applyStimulus(F3_DIV, 32'd5, 32'd0, 3, 0, 0, 0);
    applyStimulus(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 3, 0, 0, 0);
    applyStimulus(F3_DIV, -32'sd20, 32'd3, 4, 0, 0, 0);
    applyStimulus(F3_DIV, -32'sd20, 32'd3, 4, 0, 0, 0);
    applyStimulus(F3_DIV, 32'd1000, 32'd9, 5, 0, 3, 0);
    applyStimulus(F3_DIV, 32'd1000, 32'd9, 3, 0, 0, 0);
    applyStimulus(F3_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, 2, 4, 0, 0);
    applyStimulus(F3_DIVU, 32'd55, 32'd4, 2, 0, 2, 0);
    applyStimulus(F3_MULH, 32'hF000_0001, 32'h7000_0003, 3, 0, 1, 1);
    applyStimulus(F3_MULHSU, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1, 1, 0, 0);

    $display("[TB] asynchronous reset mid-wait");
    @(negedge clk);
    opValid = 1'b1; funct3 = F3_DIV; opA = 32'd77; opB = 32'd5;
    @(negedge clk);
    #1;
    checkOutput("pre_rst_div_en", divEn, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_div_en", divEn, 0);
    checkOutput("midrst_result", result, 0);
    checkOutput("midrst_unit_abort", unitAbort, 0);
    opValid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mValid = 1'b0;
    applyStimulus(F3_MULHSU, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 2, 0, 0, 0);

    $display("[TB] randomized ops");
    rf3 = F3_MUL; ra = 32'd1; rb = 32'd1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        rf3 = 3'($urandom_range(0, 7));
        ra  = pickOperand();
        rb  = pickOperand();
      end
      rAbort = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0;
      applyStimulus(rf3, ra, rb, $urandom_range(1, 4), $urandom_range(0, 3), rAbort,
                    1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
